alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// Sequencer between the operand counters, the ALU mux and the I2C display driver.
// On request it snapshots both operands, steps op_select through every ALU opcode,
// captures each result, and hands it to the display via a req/ack handshake.
// After each result it dwells so the value stays readable. Runs one scan or repeats continuously.
// PARAMETERS
// WIDTH         8           operand width
// RES_WIDTH     16          ALU result width; must equal 16 (4 display nibbles)
// OP_WIDTH      3           opcode width
// NUM_OPS       6           opcodes 0..NUM_OPS-1 are scanned; 1 <= NUM_OPS <= 2**OP_WIDTH
// SETTLE_CYCLES 2           cycles from op/operand change to result capture; >= 1
// DWELL_CYCLES  10_000_000  display hold per result (100 ms at 100 MHz); >= 1
// ACK_TIMEOUT   1_000_000   max cycles disp_req_o waits for disp_ack_i; >= 1
// PORTS
// clk_i           in   1            system clock (clk_100 domain)
// reset_i         in   1            synchronous reset, active-high
// start_i         in   1            level; sampled only in IDLE; starts one scan
// auto_i          in   1            level; 1 = restart a new scan after each scan ends
// abort_i         in   1            level; return to IDLE on the next edge
// num_1_i         in   WIDTH        live counter 1 value
// num_2_i         in   WIDTH        live counter 2 value
// alu_result_i    in   RES_WIDTH    ALU mux output for num_1_o/num_2_o/op_select_o
// disp_ack_i      in   1            display driver accepted disp_data_o
// num_1_o         out  WIDTH        snapshotted operand 1 to ALU
// num_2_o         out  WIDTH        snapshotted operand 2 to ALU
// op_select_o     out  OP_WIDTH     current opcode to ALU
// disp_data_o     out  [3:0][3:0]   captured result; [3] = bits 15:12 ... [0] = bits 3:0
// disp_req_o      out  1            display update request
// busy_o          out  1            1 whenever state != IDLE
// scan_done_o     out  1            one-cycle pulse at the end of each scan
// timeout_err_o   out  1            sticky; set when an ack times out
// BEHAVIOUR
// Reset: state = IDLE. All outputs are 0: operands, op, disp_data, req, busy, done, err.
// timeout_err_o clears only on reset.
// FSM states: IDLE, LOAD, SETTLE, CAPTURE, REQ, DWELL.
// - IDLE: move to LOAD when start_i=1 or auto_i=1.
// - LOAD (1 cyc): num_x_o <= num_x_i; op_select_o <= 0; then SETTLE.
// - SETTLE: stay exactly SETTLE_CYCLES cycles; then CAPTURE.
// - CAPTURE (1 cyc): disp_data_o <= alu_result_i; then REQ.
// - REQ: disp_req_o=1 while in this state.
//   - disp_ack_i=1 sampled -> DWELL; req is low from the next cycle.
//   - ACK_TIMEOUT cycles without ack -> timeout_err_o <= 1, go to DWELL.
//   - An ack seen in any other state is ignored.
// - DWELL: stay DWELL_CYCLES cycles. On exit:
//   - op_select_o < NUM_OPS-1: op_select_o++, go to SETTLE; operands are not re-sampled.
//   - op_select_o = NUM_OPS-1: scan_done_o=1 for one cycle; op_select_o <= 0; go to LOAD
//     if auto_i=1 (fresh snapshot), otherwise IDLE.
// Latency: start sampled at edge E -> first disp_req_o high in cycle E+SETTLE_CYCLES+3.
// Abort: abort_i=1 in any non-IDLE state -> IDLE on the next edge.
//   - req drops at once; num_x_o, op_select_o and disp_data_o hold their values; no scan_done_o.
//   - abort_i beats start_i/auto_i when both are high, also in IDLE.
// start_i held high after a scan starts a new scan: it is treated as a level in IDLE.
// Operand changes on num_x_i during a scan are invisible until the next LOAD.
// NUM_OPS=1: each scan is LOAD, SETTLE, CAPTURE, REQ, DWELL, then done.
// A single timer serves SETTLE, REQ timeout and DWELL.
//   - It loads on state entry; its width is $clog2(max of the three counts + 1).
// STRUCTURE
// alu_seq_pkg holds:
//   - seq_state_t enum {IDLE, LOAD, SETTLE, CAPTURE, REQ, DWELL};
//   - the opcode constants shared with alu_mux;
//   - the helper function nibbles(16b) -> [3:0][3:0].
// Sub-module alu_seq_timer: loadable down-counter with load_i, count_i, zero_o.
//   Parameterised on counter width.
// The FSM, operand/result registers and handshake live in alu_op_sequencer.
// Integration: the top replaces its num_select case with disp_data_o and feeds disp_req_o to the display.
// TESTING (bench parameters: NUM_OPS=4, SETTLE=2, DWELL=4, ACK_TIMEOUT=8)
// 1) num_1=0x12, num_2=0x34; start pulse; ack 1 cycle after each req.
//    -> four reqs with op 0,1,2,3; disp_data = model(0x12,0x34,op); scan_done once; then IDLE.
// 2) Start sampled at edge E, immediate ack.
//    -> req first high in cycle E+5; op_select_o=0; busy_o high from E+1.
// 3) No ack ever.
//    -> req high exactly 8 cycles per op; timeout_err_o=1 after op 0 and stays 1; scan still
//       completes.
// 4) auto_i=1; change num_1 to 0x55 mid-scan.
//    -> current scan still uses the old value; the next scan's LOAD captures 0x55; op wraps
//       3 -> 0.
// 5) abort_i during REQ of op 2 together with start_i.
//    -> req low at once; IDLE next edge; op_select_o stays 2; no scan_done; no new start
//       while abort is high.
// 6) reset_i=1 during DWELL.
//    -> next cycle every output is 0; a later start rescans from op 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer and the ALU mux.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    REQ,
    DWELL
  } seq_state_t;

  // Opcode map shared with alu_mux; the sequencer scans them in numeric order.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam int DISP_NIBBLES = 4;

  function automatic logic [DISP_NIBBLES-1:0][3:0] nibbles(input logic [15:0] value);
    logic [DISP_NIBBLES-1:0][3:0] n;
    for (int i = 0; i < DISP_NIBBLES; i++) begin
      n[i] = value[4*i +: 4];
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ALU operand/opcode bus plus display req/ack handshake between sequencer and peers.
interface alu_op_sequencer_if #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 16,
  parameter int OP_WIDTH  = 3
);
  logic [WIDTH-1:0]     num_1_o;
  logic [WIDTH-1:0]     num_2_o;
  logic [OP_WIDTH-1:0]  op_select_o;
  logic [RES_WIDTH-1:0] alu_result_i;
  logic [3:0][3:0]      disp_data_o;
  logic                 disp_req_o;
  logic                 disp_ack_i;

  modport master (
    output num_1_o,
    output num_2_o,
    output op_select_o,
    output disp_data_o,
    output disp_req_o,
    input  alu_result_i,
    input  disp_ack_i
  );

  modport slave (
    input  num_1_o,
    input  num_2_o,
    input  op_select_o,
    input  disp_data_o,
    input  disp_req_o,
    output alu_result_i,
    output disp_ack_i
  );
endinterface

// File: rtl/alu_seq_timer.sv
// Loadable down-counter shared by the settle, ack-timeout and dwell intervals.
module alu_seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             count_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Snapshots operands, steps the ALU through every opcode and hands each result
// to the display over a req/ack handshake, dwelling after each update.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int RES_WIDTH     = 16,
  parameter int OP_WIDTH      = 3,
  parameter int NUM_OPS       = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 10_000_000,
  parameter int ACK_TIMEOUT   = 1_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             auto_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] num_1_i,
  input  logic [WIDTH-1:0] num_2_i,
  alu_op_sequencer_if.master bus,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             timeout_err_o
);

  localparam int MAX_A   = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int MAX_CNT = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
  localparam int TIMER_W = $clog2(MAX_CNT + 1);
  localparam logic [OP_WIDTH-1:0] LAST_OP = OP_WIDTH'(NUM_OPS - 1);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [WIDTH-1:0]    num_1_q, num_1_d;
  logic [WIDTH-1:0]    num_2_q, num_2_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [3:0][3:0]     data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_count;
  logic               timer_zero;
  logic               last_op;
  logic               dwell_done;

  assign last_op    = (op_q == LAST_OP);
  assign dwell_done = (state_q == DWELL) && timer_zero && !abort_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i || auto_i) state_d = LOAD;
      LOAD:    state_d = SETTLE;
      SETTLE:  if (timer_zero) state_d = CAPTURE;
      CAPTURE: state_d = REQ;
      REQ:     if (bus.disp_ack_i || timer_zero) state_d = DWELL;
      DWELL: begin
        if (timer_zero) begin
          if (!last_op)    state_d = SETTLE;
          else if (auto_i) state_d = LOAD;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a pending start in IDLE.
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    bus.disp_req_o = (state_q == REQ) && !abort_i;
  end

  // Every timed state is entered from a different state, so a state change is the load strobe.
  always_comb begin
    timer_load  = (state_d != state_q);
    timer_count = (state_q == SETTLE) || (state_q == REQ) || (state_q == DWELL);
    unique case (state_d)
      SETTLE:  timer_value = TIMER_W'(SETTLE_CYCLES - 1);
      REQ:     timer_value = TIMER_W'(ACK_TIMEOUT - 1);
      DWELL:   timer_value = TIMER_W'(DWELL_CYCLES - 1);
      default: timer_value = '0;
    endcase
  end

  alu_seq_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .count_i      (timer_count),
    .zero_o       (timer_zero)
  );

  always_comb begin
    num_1_d = num_1_q;
    num_2_d = num_2_q;
    op_d    = op_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if ((state_q == LOAD) && (state_d == SETTLE)) begin
      num_1_d = num_1_i;
      num_2_d = num_2_i;
      op_d    = '0;
    end

    if ((state_q == CAPTURE) && (state_d == REQ)) begin
      data_d = nibbles(16'(bus.alu_result_i));
    end

    // Leaving REQ for DWELL without an ack can only mean the timeout expired.
    if ((state_q == REQ) && (state_d == DWELL) && !bus.disp_ack_i) begin
      err_d = 1'b1;
    end

    if (dwell_done) begin
      if (last_op) begin
        op_d   = '0;
        done_d = 1'b1;
      end else begin
        op_d = op_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      num_1_q <= '0;
      num_2_q <= '0;
      op_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      num_1_q <= num_1_d;
      num_2_q <= num_2_d;
      op_q    <= op_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.num_1_o     = num_1_q;
  assign bus.num_2_o     = num_2_q;
  assign bus.op_select_o = op_q;
  assign bus.disp_data_o = data_q;
  assign scan_done_o     = done_q;
  assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-plus-random bench for alu_op_sequencer with a behavioural ALU and scan model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int NOPS   = 4;
  localparam int SETTLE = 2;
  localparam int DWELL  = 4;
  localparam int ACKTO  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, auto_m, abort, ack;
  logic [7:0] n1, n2;
  logic       busy, done, err;

  alu_op_sequencer_if #(.WIDTH(8), .RES_WIDTH(16), .OP_WIDTH(3)) bus ();

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    case (op)
      OP_ADD:  return 16'(a) + 16'(b);
      OP_SUB:  return 16'(a) - 16'(b);
      OP_MUL:  return 16'(a) * 16'(b);
      OP_AND:  return {8'h00, a & b};
      OP_OR:   return {8'h00, a | b};
      OP_XOR:  return {8'h00, a ^ b};
      default: return 16'hdead;
    endcase
  endfunction

  assign bus.alu_result_i = alu_model(bus.num_1_o, bus.num_2_o, bus.op_select_o);
  assign bus.disp_ack_i   = ack;

  alu_op_sequencer #(
    .WIDTH         (8),
    .RES_WIDTH     (16),
    .OP_WIDTH      (3),
    .NUM_OPS       (NOPS),
    .SETTLE_CYCLES (SETTLE),
    .DWELL_CYCLES  (DWELL),
    .ACK_TIMEOUT   (ACKTO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .auto_i        (auto_m),
    .abort_i       (abort),
    .num_1_i       (n1),
    .num_2_i       (n2),
    .bus           (bus),
    .busy_o        (busy),
    .scan_done_o   (done),
    .timeout_err_o (err)
  );

  int         checks = 0;
  int         errors = 0;
  bit         err_exp;
  int         dly[NOPS];
  int         mid_k;
  logic [7:0] mid_val;
  logic [7:0] a_r, b_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (bus.disp_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_num_1", bus.num_1_o, 0);
    chk("rst_num_2", bus.num_2_o, 0);
    chk("rst_op", bus.op_select_o, 0);
    chk("rst_data", bus.disp_data_o, 0);
    chk("rst_req", bus.disp_req_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic random_delays();
    for (int i = 0; i < NOPS; i++) begin
      dly[i] = ($urandom_range(0, 4) == 4) ? 7 : int'($urandom_range(0, 3));
    end
  endtask

  // Entered on the cycle after start/auto was sampled (the LOAD cycle).
  task automatic run_scan(input logic [7:0] a, input logic [7:0] b, input bit auto_after,
                          input int stop_k);
    int n;
    int high;
    int exp_len;
    for (int k = 0; k < NOPS; k++) begin
      wait_req(n);
      chk("req_seen", bus.disp_req_o, 1);
      if (k == 0) chk("first_req_latency", n, SETTLE + 2);
      else        chk("req_gap", n, DWELL + SETTLE + 1);
      chk("op_select", bus.op_select_o, k);
      chk("disp_data", bus.disp_data_o, alu_model(a, b, k[2:0]));
      chk("busy_in_req", busy, 1);
      $display("scan op=%0d a=%02h b=%02h data=%04h ack_delay=%0d", k, a, b,
               bus.disp_data_o, dly[k]);
      if (k == stop_k) return;
      high = 0;
      while (bus.disp_req_o === 1'b1 && high < 20) begin
        ack = (high == dly[k]);
        high++;
        tick();
        ack = 1'b0;
      end
      exp_len = (dly[k] + 1 < ACKTO) ? dly[k] + 1 : ACKTO;
      chk("req_len", high, exp_len);
      if (dly[k] >= ACKTO) err_exp = 1'b1;
      chk("timeout_err", err, err_exp);
      if (k == mid_k) n1 = mid_val;
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("done_latency", n, DWELL);
    chk("scan_done", done, 1);
    chk("busy_at_done", busy, auto_after);
    chk("op_wrap", bus.op_select_o, 0);
    if (!auto_after) begin
      tick();
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; auto_m = 1'b0; abort = 1'b0; ack = 1'b0;
    n1 = 8'h00; n2 = 8'h00; err_exp = 1'b0; mid_k = -1; mid_val = 8'h00;
    tick();
    tick();
    check_zero_outputs();
    reset = 1'b0;
    tick();
    chk("idle_no_start", busy, 0);

    // Directed scan, ack one cycle after each request
    n1 = 8'h12; n2 = 8'h34;
    dly = '{1, 1, 1, 1};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    run_scan(8'h12, 8'h34, 1'b0, -1);

    // Random operands and ack delays; operand change mid-scan must stay invisible
    for (int r = 0; r < 3; r++) begin
      a_r = 8'($urandom); b_r = 8'($urandom);
      n1 = a_r; n2 = b_r;
      random_delays();
      mid_k = r; mid_val = ~a_r;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_scan(a_r, b_r, 1'b0, -1);
    end
    mid_k = -1;

    // No ack at all: every request times out
    a_r = 8'($urandom); b_r = 8'($urandom);
    n1 = a_r; n2 = b_r;
    dly = '{20, 20, 20, 20};
    start = 1'b1;
    tick();
    start = 1'b0;
    run_scan(a_r, b_r, 1'b0, -1);
    tick();
    chk("err_sticky", err, 1);

    // Auto mode: new num_1 only seen by the following scan's snapshot
    b_r = 8'($urandom);
    n1 = 8'h20; n2 = b_r;
    random_delays();
    mid_k = 1; mid_val = 8'h55;
    auto_m = 1'b1;
    tick();
    chk("auto_busy", busy, 1);
    run_scan(8'h20, b_r, 1'b1, -1);
    mid_k = -1;
    auto_m = 1'b0;
    random_delays();
    run_scan(8'h55, b_r, 1'b0, -1);

    // Abort during REQ of op 2 together with start
    a_r = 8'($urandom); b_r = 8'($urandom);
    n1 = a_r; n2 = b_r;
    dly = '{0, 0, 0, 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    run_scan(a_r, b_r, 1'b0, 2);
    abort = 1'b1; start = 1'b1;
    #1;
    chk("abort_req_drop", bus.disp_req_o, 0);
    tick();
    chk("abort_idle", busy, 0);
    chk("abort_op_hold", bus.op_select_o, 2);
    chk("abort_data_hold", bus.disp_data_o, alu_model(a_r, b_r, 3'd2));
    chk("abort_no_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_beats_start", busy, 0);
      chk("abort_no_done_later", done, 0);
    end
    abort = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_abort", busy, 0);

    // Reset while dwelling, then a fresh scan from op 0
    a_r = 8'($urandom); b_r = 8'($urandom);
    n1 = a_r; n2 = b_r;
    dly = '{0, 0, 0, 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    run_scan(a_r, b_r, 1'b0, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dwell_req_low", bus.disp_req_o, 0);
    chk("dwell_busy", busy, 1);
    tick();
    reset = 1'b1;
    tick();
    check_zero_outputs();
    reset = 1'b0;
    err_exp = 1'b0;
    a_r = 8'($urandom); b_r = 8'($urandom);
    n1 = a_r; n2 = b_r;
    random_delays();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_scan(a_r, b_r, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
